// File: rtl/query_patch_writer_pkg.sv
// Shared types and default sizing for the query patch writer.
package qpw_pkg;

  localparam int DEF_DATA_WIDTH = 11;
  localparam int DEF_PATCH_SIZE = 5;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DEPTH      = 512;
  localparam int PATCH_W        = DEF_DATA_WIDTH * DEF_PATCH_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } qpw_state_e;

  // Counter width that stays legal for a single-entry range.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/query_patch_writer_if.sv
// Pixel stream and patch-memory write port bundles.
interface qpw_pix_if #(
  parameter int DATA_WIDTH = qpw_pkg::DEF_DATA_WIDTH
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_pixel;

  modport master (output in_valid, output in_pixel, input  in_ready);
  modport slave  (input  in_valid, input  in_pixel, output in_ready);
endinterface

interface qpw_mem_if #(
  parameter int DATA_WIDTH = qpw_pkg::DEF_DATA_WIDTH,
  parameter int PATCH_SIZE = qpw_pkg::DEF_PATCH_SIZE,
  parameter int ADDR_WIDTH = qpw_pkg::DEF_ADDR_WIDTH
) ();
  logic                             csb0;
  logic                             web0;
  logic [ADDR_WIDTH-1:0]            addr0;
  logic [DATA_WIDTH*PATCH_SIZE-1:0] wpatch0;

  modport master (output csb0, output web0, output addr0, output wpatch0);
  modport slave  (input  csb0, input  web0, input  addr0, input  wpatch0);
endinterface

// File: rtl/query_patch_writer_patch_packer.sv
// Lane accumulator: packs PATCH_SIZE pixels into one patch word. The
// completed patch (including the pixel arriving this cycle) is presented
// combinationally with patch_valid so the caller can register it on the
// same edge that accepts the last pixel.
module patch_packer import qpw_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PATCH_SIZE = DEF_PATCH_SIZE
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             accept,
  input  logic [DATA_WIDTH-1:0]            in_pixel,
  output logic                             patch_valid,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] patch
);

  localparam int              CNT_W = cnt_w(PATCH_SIZE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PATCH_SIZE - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] lane_q, lane_d, patch_lanes;
  logic [CNT_W-1:0]                      pix_cnt_q, pix_cnt_d;

  // Steer the accepted pixel into its lane and advance the lane counter.
  always_comb begin
    lane_d      = lane_q;
    patch_lanes = lane_q;
    pix_cnt_d   = pix_cnt_q;
    for (int l = 0; l < PATCH_SIZE; l++) begin
      if (accept && (pix_cnt_q == CNT_W'(l))) begin
        lane_d[l]      = in_pixel;
        patch_lanes[l] = in_pixel;
      end
    end
    if (clr)
      pix_cnt_d = '0;
    else if (accept)
      pix_cnt_d = (pix_cnt_q == LAST) ? '0 : pix_cnt_q + ONE;
  end

  assign patch_valid = accept && (pix_cnt_q == LAST);
  assign patch       = patch_lanes;

  // Lane storage and counter; reset drops any partial patch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q    <= '0;
      pix_cnt_q <= '0;
    end else begin
      lane_q    <= lane_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

endmodule

// File: rtl/query_patch_writer.sv
// Streams pixels into patches and writes each patch to the query patch
// memory at consecutive addresses from 0; pulses done after the last one.
module query_patch_writer import qpw_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PATCH_SIZE = DEF_PATCH_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_WIDTH:0] num_patches,
  output logic              busy,
  output logic              done,
  qpw_pix_if.slave          pix,
  qpw_mem_if.master         mem
);

  localparam int                  PW      = DATA_WIDTH * PATCH_SIZE;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  qpw_state_e            state_q, state_d;
  logic [ADDR_WIDTH:0]   target_q, target_d;
  logic [ADDR_WIDTH:0]   patch_idx_q, patch_idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PW-1:0]         wpatch_q, wpatch_d;

  logic          in_ready;
  logic          accept;
  logic          clr;
  logic          patch_valid;
  logic [PW-1:0] patch;

  // in_ready is the only output decoded straight from the state register.
  assign in_ready     = (state_q == LOAD);
  assign pix.in_ready = in_ready;
  assign accept       = pix.in_valid && in_ready;
  assign clr          = (state_q == IDLE) && start && (num_patches != '0);

  patch_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .PATCH_SIZE (PATCH_SIZE)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .accept      (accept),
    .in_pixel    (pix.in_pixel),
    .patch_valid (patch_valid),
    .patch       (patch)
  );

  // Next-state, patch indexing and memory-side register updates.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    patch_idx_d = patch_idx_q;
    addr_d      = addr_q;
    wpatch_d    = wpatch_q;
    done_d      = 1'b0;
    csb_d       = 1'b1;
    web_d       = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_patches == '0) begin
            done_d = 1'b1;
          end else begin
            target_d    = (num_patches > DEPTH_C) ? DEPTH_C : num_patches;
            patch_idx_d = '0;
            state_d     = LOAD;
          end
        end
      end
      LOAD: begin
        if (patch_valid) begin
          // Strobe is registered, so the write lands one edge after the
          // last pixel; the packer is already free for the next patch.
          wpatch_d    = patch;
          addr_d      = patch_idx_q[ADDR_WIDTH-1:0];
          csb_d       = 1'b0;
          web_d       = 1'b0;
          patch_idx_d = patch_idx_q + IDX_ONE;
          if (patch_idx_q == target_q - IDX_ONE)
            state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // All FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      target_q    <= '0;
      patch_idx_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      csb_q       <= 1'b1;
      web_q       <= 1'b1;
      addr_q      <= '0;
      wpatch_q    <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      patch_idx_q <= patch_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      addr_q      <= addr_d;
      wpatch_q    <= wpatch_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem.csb0    = csb_q;
  assign mem.web0    = web_q;
  assign mem.addr0   = addr_q;
  assign mem.wpatch0 = wpatch_q;

endmodule
